// File: rtl/dlfloat16_pkg.sv
// dlfloat16_pkg: DLFloat16 extended-result field positions, exception indices and constants
package dlfloat16_pkg;
  localparam int SIGN_B = 19;
  localparam int EXP_HI = 18;
  localparam int EXP_LO = 13;
  localparam int MANT_HI = 12;
  localparam int MANT_LO = 4;
  localparam int G_B = 3;
  localparam int R_B = 2;
  localparam int S_HI = 1;
  localparam int S_LO = 0;
  localparam int EXC_INV = 4;
  localparam int EXC_INX = 3;
  localparam int EXC_OVF = 2;
  localparam int EXC_UNF = 1;
  localparam int EXC_ZER = 0;
  localparam logic [15:0] DLF_NAN = 16'hFFFF;
  localparam logic [5:0] EXP_MAX = 6'd63;
  typedef logic [4:0] exc_t;
endpackage

// File: rtl/dlfloat16_rne_round.sv
// dlfloat16_rne_round: combinational round-to-nearest-even (or truncate) with saturation and specials
module dlfloat16_rne_round
  import dlfloat16_pkg::*;
#(
  parameter logic [15:0] SAT_POS = 16'h7DFE,
  parameter logic [15:0] SAT_NEG = 16'hFDFE
) (
  input  logic [19:0] d,
  input  logic        rmode,
  output logic [15:0] q,
  output logic [4:0]  exc
);
  logic sign, g, r, st, up, nan, zer, sat;
  logic [5:0] e, er;
  logic [8:0] m;
  logic [9:0] mr;
  exc_t f;
  assign sign = d[SIGN_B];
  assign e = d[EXP_HI:EXP_LO];
  assign m = d[MANT_HI:MANT_LO];
  assign g = d[G_B];
  assign r = d[R_B];
  assign st = |d[S_HI:S_LO];
  assign up = ~rmode & g & (r | st | m[0]);
  assign mr = {1'b0, m} + 10'(up);
  assign er = e + 6'(mr[9]);
  assign nan = (e == EXP_MAX);
  assign zer = (e == 6'd0);
  // 0x7DFF and above are not finite encodings, so both land on the saturation value
  assign sat = ~nan & ~zer & ((er == EXP_MAX) | ((er == EXP_MAX - 6'd1) & (mr[8:0] == 9'h1FF)));
  always_comb begin
    f = '0;
    f[EXC_INV] = nan;
    f[EXC_ZER] = zer;
    f[EXC_OVF] = sat;
    f[EXC_INX] = ~nan & ~zer & (sat | g | r | st);
    exc = f;
    q = nan ? DLF_NAN : zer ? 16'h0000 : sat ? (sign ? SAT_NEG : SAT_POS) : {sign, er, mr[8:0]};
  end
endmodule

// File: rtl/dlfloat16_round_pack.sv
// dlfloat16_round_pack: 2-stage round/pack pipeline with valid/ready, sticky flags and result counter; DLF16_RMODE_EN adds rmode (1 = truncate)
module dlfloat16_round_pack
  import dlfloat16_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter logic [15:0] SAT_POS = 16'h7DFE,
  parameter logic [15:0] SAT_NEG = 16'hFDFE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [19:0]      in_data,
  input  logic [4:0]       in_exc,
`ifdef DLF16_RMODE_EN
  input  logic             rmode,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [4:0]       out_exc,
  input  logic             flag_clr,
  output logic [4:0]       sticky_exc,
  output logic [CNT_W-1:0] res_cnt
);
  logic s1_valid, s2_adv, in_fire, out_fire, rm;
  logic [15:0] rd_data, s1_data;
  exc_t rd_exc, s1_exc;
`ifdef DLF16_RMODE_EN
  assign rm = rmode;
`else
  assign rm = 1'b0;
`endif
  dlfloat16_rne_round #(.SAT_POS(SAT_POS), .SAT_NEG(SAT_NEG)) u_round (
    .d(in_data),
    .rmode(rm),
    .q(rd_data),
    .exc(rd_exc)
  );
  assign s2_adv = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_exc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_exc <= '0;
      sticky_exc <= '0;
      res_cnt <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_fire) begin
        s1_data <= rd_data;
        s1_exc <= rd_exc | in_exc;
      end
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv & s1_valid) begin
        out_data <= s1_data;
        out_exc <= s1_exc;
      end
      sticky_exc <= (flag_clr ? 5'b0 : sticky_exc) | (out_fire ? out_exc : 5'b0);
      res_cnt <= res_cnt + CNT_W'(out_fire);
    end
  end
endmodule

// File: tb/tb_dlfloat16_round_pack.sv
// tb_dlfloat16_round_pack: directed vectors, handshake sequences and randomized scoreboard for dlfloat16_round_pack
module tb_dlfloat16_round_pack;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, flag_clr = 0, rmode_v = 0;
  logic [19:0] in_data = '0;
  logic [4:0] in_exc = '0;
  logic in_ready, out_valid;
  logic [15:0] out_data, res_cnt;
  logic [4:0] out_exc, sticky_exc;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dlfloat16_round_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_exc(in_exc),
`ifdef DLF16_RMODE_EN
    .rmode(rmode_v),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_exc(out_exc),
    .flag_clr(flag_clr), .sticky_exc(sticky_exc), .res_cnt(res_cnt)
  );

  typedef struct {
    string n;
    logic [19:0] d;
    logic [4:0] e;
    logic rm;
    logic [15:0] q;
    logic [4:0] x;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want_v);
    total++;
    if (act !== want_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want_v);
    end
  endtask

  // value-level model: magnitude = exp*512 + mant, rounding adds one unit in the last place
  function automatic logic [20:0] ref_model(input logic [19:0] d, input logic [4:0] ie, input logic rm);
    int e, m, rem, up, mag;
    logic [15:0] q;
    logic [4:0] f;
    e = int'(d[18:13]);
    m = int'(d[12:4]);
    rem = int'(d[3]) * 4 + int'(d[2]) * 2 + int'(|d[1:0]);
    f = '0;
    if (e == 63) begin
      q = 16'hFFFF;
      f[4] = 1'b1;
    end else if (e == 0) begin
      q = 16'h0000;
      f[0] = 1'b1;
    end else begin
      up = (!rm && (rem > 4 || (rem == 4 && m % 2 == 1))) ? 1 : 0;
      mag = e * 512 + m + up;
      if (mag >= 'h7DFF) begin
        q = d[19] ? 16'hFDFE : 16'h7DFE;
        f[2] = 1'b1;
        f[3] = 1'b1;
      end else begin
        q = {d[19], 15'(mag)};
        f[3] = (rem != 0);
      end
    end
    return {q, f | ie};
  endfunction

  logic [20:0] sbq[$];
  logic [20:0] want, held_v;
  logic [4:0] fexc;
  logic held = 0;
  logic [4:0] m_sticky = '0;
  logic [15:0] m_cnt = '0;
  int n_out = 0;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      held = 0;
      m_sticky = '0;
      m_cnt = '0;
    end else begin
      check("res_cnt", res_cnt, m_cnt);
      check("sticky", sticky_exc, m_sticky);
      if (held) check("stall_hold", {out_valid, out_data, out_exc}, {1'b1, held_v});
      fexc = '0;
      if (out_valid && out_ready) begin
        n_out++;
        m_cnt++;
        if (sbq.size() == 0) check("sb_extra", 32'(sbq.size()), 32'd1);
        else begin
          want = sbq.pop_front();
          fexc = want[4:0];
          check("sb_data", {out_data, out_exc}, want);
        end
      end
      m_sticky = (flag_clr ? 5'b0 : m_sticky) | fexc;
      held = out_valid && !out_ready;
      held_v = {out_data, out_exc};
      if (in_valid && in_ready) sbq.push_back(ref_model(in_data, in_exc, rmode_v));
    end
  end

  function automatic vec_t mk(input string n, input logic [19:0] d, input logic [4:0] e, input logic rm,
                              input logic [15:0] q, input logic [4:0] x);
    vec_t v;
    v.n = n; v.d = d; v.e = e; v.rm = rm; v.q = q; v.x = x;
    return v;
  endfunction

  task automatic apply_vec(input vec_t v);
    @(posedge clk); #1;
    in_valid = 1; in_data = v.d; in_exc = v.e; rmode_v = v.rm; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    check({v.n, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({v.n, "_lat2"}, 32'(out_valid), 32'd1);
    check({v.n, "_data"}, 32'(out_data), 32'(v.q));
    check({v.n, "_exc"}, 32'(out_exc), 32'(v.x));
  endtask

  logic [19:0] b[8];
  logic [19:0] d;
  logic f;
  int sent, cyc, n0;

  initial begin
    vecs.push_back(mk("tie_even", {1'b0, 6'd31, 9'h0AA, 4'b1000}, 5'd0, 1'b0, 16'h3EAA, 5'b01000));
    vecs.push_back(mk("tie_odd", {1'b0, 6'd31, 9'h0AB, 4'b1000}, 5'd0, 1'b0, 16'h3EAC, 5'b01000));
    vecs.push_back(mk("carry", {1'b0, 6'd40, 9'h1FF, 4'b1100}, 5'd0, 1'b0, 16'h5200, 5'b01000));
    vecs.push_back(mk("ovf_neg", {1'b1, 6'd62, 9'h1FF, 4'b1000}, 5'd0, 1'b0, 16'hFDFE, 5'b01100));
    vecs.push_back(mk("nan", {1'b0, 6'd63, 9'h000, 4'b0000}, 5'd0, 1'b0, 16'hFFFF, 5'b10000));
    vecs.push_back(mk("zero", {1'b1, 6'd0, 9'h055, 4'b1111}, 5'd0, 1'b0, 16'h0000, 5'b00001));
    vecs.push_back(mk("exact", {1'b0, 6'd10, 9'h123, 4'b0000}, 5'd0, 1'b0, 16'h1523, 5'b00000));
    vecs.push_back(mk("exc_pass", {1'b0, 6'd10, 9'h123, 4'b0000}, 5'b00010, 1'b0, 16'h1523, 5'b00010));
    vecs.push_back(mk("max_sat", {1'b0, 6'd62, 9'h1FF, 4'b0000}, 5'd0, 1'b0, 16'h7DFE, 5'b01100));
    vecs.push_back(mk("below_up", {1'b0, 6'd31, 9'h0AA, 4'b1001}, 5'd0, 1'b0, 16'h3EAB, 5'b01000));
`ifdef DLF16_RMODE_EN
    vecs.push_back(mk("rtz", {1'b0, 6'd31, 9'h0AA, 4'b1111}, 5'd0, 1'b1, 16'h3EAA, 5'b01000));
    vecs.push_back(mk("rtz_carry", {1'b0, 6'd40, 9'h1FF, 4'b1100}, 5'd0, 1'b1, 16'h51FF, 5'b01000));
    vecs.push_back(mk("rtz_sat", {1'b0, 6'd62, 9'h1FF, 4'b1111}, 5'd0, 1'b1, 16'h7DFE, 5'b01100));
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_od", 32'(out_data), 32'd0);
    check("rst_oe", 32'(out_exc), 32'd0);
    check("rst_sticky", 32'(sticky_exc), 32'd0);
    check("rst_cnt", 32'(res_cnt), 32'd0);
    check("rst_ir", 32'(in_ready), 32'd1);
    rst = 0;
    foreach (vecs[i]) apply_vec(vecs[i]);

    rmode_v = 0;
    @(posedge clk); #1; flag_clr = 1;
    @(posedge clk); #1; flag_clr = 0;
    check("clr_idle", 32'(sticky_exc), 32'd0);
    apply_vec(vecs[3]);
    @(posedge clk); #1;
    check("sticky_ovf", 32'(sticky_exc), 32'b01100);
    in_valid = 1; in_data = {1'b0, 6'd0, 9'h0, 4'b0}; in_exc = 0;
    @(posedge clk); #1; in_valid = 0;
    @(posedge clk); #1; flag_clr = 1;
    @(posedge clk); #1; flag_clr = 0;
    check("clr_fire", 32'(sticky_exc), 32'b00001);
    flag_clr = 1;
    @(posedge clk); #1; flag_clr = 0;
    check("clr_alone", 32'(sticky_exc), 32'd0);

    @(posedge clk); #1;
    out_ready = 0; in_valid = 1; in_data = {1'b0, 6'd20, 9'h011, 4'b0000};
    @(posedge clk); #1; in_data = {1'b1, 6'd21, 9'h022, 4'b0000};
    @(posedge clk); #1; in_valid = 0;
    check("full_ov", 32'(out_valid), 32'd1);
    check("full_ir", 32'(in_ready), 32'd0);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(res_cnt), 32'd0);
    check("mid_rst_ir", 32'(in_ready), 32'd1);

    foreach (b[i]) b[i] = {1'($urandom), 6'($urandom_range(1, 62)), 9'($urandom), 4'($urandom)};
    n0 = n_out; sent = 0; cyc = 0;
    @(posedge clk); #1;
    in_valid = 1; in_data = b[0]; in_exc = 0; out_ready = 1;
    while (sent < 8 && cyc < 100) begin
      @(negedge clk); f = in_ready;
      @(posedge clk); #1; cyc++;
      out_ready = (cyc % 2 == 0);
      if (f) begin
        sent++;
        if (sent < 8) in_data = b[sent]; else in_valid = 0;
      end
    end
    while (n_out - n0 < 8 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
      out_ready = (cyc % 2 == 0);
    end
    check("burst_outs", 32'(n_out - n0), 32'd8);
    check("burst_cnt", 32'(res_cnt), 32'd8);

    repeat (600) begin
      @(posedge clk); #1;
      d = 20'($urandom);
      case ($urandom_range(0, 5))
        0: d[18:13] = 6'd0;
        1: d[18:13] = 6'd63;
        2: d[18:4] = {6'd62, 9'h1FF};
        default: ;
      endcase
      in_valid = 1'($urandom_range(0, 1));
      in_data = d;
      in_exc = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      out_ready = ($urandom_range(0, 3) != 0);
      flag_clr = ($urandom_range(0, 15) == 0);
`ifdef DLF16_RMODE_EN
      rmode_v = 1'($urandom_range(0, 1));
`endif
    end
    @(posedge clk); #1;
    in_valid = 0; flag_clr = 0; out_ready = 1;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check("drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
